// File: rtl/i2c_adc24_reader.sv
// i2c_adc24_reader
// Autonomous I2C master for the 24-bit serial ADC. A falling DRDY starts a
// read of three bytes from DEV_ADDR. Each bit is split into four quarters of
// DIV_QTR clocks. A complete read produces a signed 24-bit sample with a
// one-cycle valid strobe.
// SCL and SDA are open-drain: an *_oe output of 1 pulls the line low.

module i2c_adc24_reader #(
  parameter int unsigned DIV_QTR  = 100,
  parameter logic [6:0]  DEV_ADDR = 7'h40
) (
  input  logic        pll_clk_cpu_int,
  input  logic        RST_EXT_N,
  input  logic        i_enable,
  input  logic        DRDY_ADC,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_scl_oe,
  output logic        o_sda_oe,
  output logic [23:0] o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_nack_err,
  output logic [15:0] o_overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_READ,
    S_MACK,
    S_STOP
  } state_t;

  // Last count of a quarter, and the first quarter position at which a low
  // synced SCL is taken as slave stretching. Checking stretch from count 2
  // lets the two-flop SCL synchroniser settle after the master releases SCL.
  // As a result, a bus that is not stretched loses no cycles.
  localparam logic [11:0] QTR_LAST  = 12'(DIV_QTR - 1);
  localparam logic [11:0] HOLD_AT   = (DIV_QTR > 2) ? 12'd2 : 12'd1;
  localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, 1'b1};

  state_t      state;
  state_t      next_state;

  logic        drdy_meta;
  logic        drdy_sync;
  logic        drdy_prev;
  logic        scl_meta;
  logic        scl_sync;
  logic        drdy_fall;

  logic [11:0] qcnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic        nack_bit;
  logic [23:0] shift_reg;
  logic        got_all;

  logic        bit_state;
  logic        stretch_hold;
  logic        qtick;
  logic        last_q;
  logic        sample_now;

  // Synchronise DRDY and SCL into the clock domain, and keep the previous
  // synced DRDY value for falling-edge detection.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      drdy_meta <= 1'b0;
      drdy_sync <= 1'b0;
      drdy_prev <= 1'b0;
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
    end else begin
      drdy_meta <= DRDY_ADC;
      drdy_sync <= drdy_meta;
      drdy_prev <= drdy_sync;
      scl_meta  <= i_scl;
      scl_sync  <= scl_meta;
    end
  end

  assign drdy_fall = drdy_prev & ~drdy_sync;

  // Quarter timing. Clock stretching is honoured only in the four states
  // that clock data bits. START and STOP run on fixed timing.
  always_comb begin
    bit_state = (state == S_ADDR) || (state == S_AACK) ||
                (state == S_READ) || (state == S_MACK);
  end

  // Hold the quarter counter while the slave keeps SCL low in Q2.
  always_comb begin
    stretch_hold = bit_state && (phase == 2'd2) && !scl_sync && (qcnt >= HOLD_AT);
  end

  // Quarter tick, end-of-bit strobe, and the SDA sampling point.
  always_comb begin
    qtick      = (state != S_IDLE) && (qcnt == QTR_LAST) && !stretch_hold;
    last_q     = qtick && (phase == 2'd3);
    sample_now = ((state == S_AACK) || (state == S_READ)) &&
                 (phase == 2'd3) && (qcnt == 12'd0);
  end

  // State register.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Every state except IDLE advances only when the last
  // quarter of its current bit ends.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (drdy_fall && i_enable) next_state = S_START;
      end
      S_START: begin
        if (last_q) next_state = S_ADDR;
      end
      S_ADDR: begin
        if (last_q && (bit_cnt == 3'd7)) next_state = S_AACK;
      end
      S_AACK: begin
        if (last_q) next_state = nack_bit ? S_STOP : S_READ;
      end
      S_READ: begin
        if (last_q && (bit_cnt == 3'd7)) next_state = S_MACK;
      end
      S_MACK: begin
        if (last_q) next_state = (byte_idx == 2'd2) ? S_STOP : S_READ;
      end
      S_STOP: begin
        if (last_q) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Quarter, phase and bit counters. They return to zero in IDLE so each
  // transfer starts from a clean phase. bit_cnt wraps from 7 back to 0, so
  // it is ready for the next byte.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      qcnt    <= 12'd0;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
    end else if (state == S_IDLE) begin
      qcnt    <= 12'd0;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
    end else if (qtick) begin
      qcnt  <= 12'd0;
      phase <= phase + 2'd1;
      if ((phase == 2'd3) && ((state == S_ADDR) || (state == S_READ))) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else if (!stretch_hold) begin
      qcnt <= qcnt + 12'd1;
    end
  end

  // Receive datapath: address acknowledge, incoming data bits and byte
  // index. o_data and o_valid are published only when STOP ends a transfer
  // that read all three bytes.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      byte_idx   <= 2'd0;
      nack_bit   <= 1'b0;
      shift_reg  <= 24'd0;
      got_all    <= 1'b0;
      o_data     <= 24'd0;
      o_valid    <= 1'b0;
      o_nack_err <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_nack_err <= 1'b0;
      if (state == S_START) begin
        byte_idx <= 2'd0;
        got_all  <= 1'b0;
      end
      if (sample_now && (state == S_AACK)) begin
        nack_bit <= i_sda;
      end
      if (sample_now && (state == S_READ)) begin
        shift_reg <= {shift_reg[22:0], i_sda};
      end
      if ((state == S_AACK) && last_q && nack_bit) begin
        o_nack_err <= 1'b1;
      end
      if ((state == S_MACK) && last_q) begin
        if (byte_idx == 2'd2) begin
          got_all <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if ((state == S_STOP) && last_q && got_all) begin
        o_data  <= shift_reg;
        o_valid <= 1'b1;
      end
    end
  end

  // Count DRDY falls that arrive while a transfer is active. The counter
  // saturates at 16'hFFFF.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      o_overrun_cnt <= 16'd0;
    end else if (drdy_fall && (state != S_IDLE) && (o_overrun_cnt != 16'hFFFF)) begin
      o_overrun_cnt <= o_overrun_cnt + 16'd1;
    end
  end

  // Bus drive decoded from the state and the quarter phase. In the data bit
  // states, SCL is pulled low in Q0 and Q1 and released in Q2 and Q3.
  always_comb begin
    o_scl_oe = 1'b0;
    o_sda_oe = 1'b0;
    o_busy   = (state != S_IDLE);
    case (state)
      S_START: begin
        o_sda_oe = 1'b1;
        o_scl_oe = phase[1];
      end
      S_ADDR: begin
        o_scl_oe = !phase[1];
        o_sda_oe = !ADDR_BYTE[3'd7 - bit_cnt];
      end
      S_AACK, S_READ: begin
        o_scl_oe = !phase[1];
        o_sda_oe = 1'b0;
      end
      S_MACK: begin
        o_scl_oe = !phase[1];
        o_sda_oe = (byte_idx != 2'd2);
      end
      S_STOP: begin
        o_scl_oe = (phase == 2'd0);
        o_sda_oe = !phase[1];
      end
      default: begin
        o_scl_oe = 1'b0;
        o_sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_adc24_reader.sv
// Testbench for i2c_adc24_reader. A bit-level ADC slave model watches the
// open-drain bus and answers reads. Expected samples are queued when a
// transfer is launched and compared when o_valid fires.

module tb_i2c_adc24_reader;

  logic        pll_clk_cpu_int = 1'b0;
  logic        RST_EXT_N = 1'b0;
  logic        i_enable = 1'b1;
  logic        DRDY_ADC = 1'b1;
  logic        o_scl_oe;
  logic        o_sda_oe;
  logic [23:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_nack_err;
  logic [15:0] o_overrun_cnt;

  logic        slave_scl_low = 1'b0;
  logic        slave_sda_low = 1'b0;
  logic        scl_pad;
  logic        sda_pad;

  int check_count = 0;
  int error_count = 0;

  logic [23:0] exp_q[$];
  logic [23:0] adc_word = 24'd0;
  logic        nack_mode = 1'b0;
  logic        stretch_req = 1'b0;

  // Slave model state.
  logic        slave_active = 1'b0;
  int          byte_no = 0;
  int          nbit = 0;
  int          stretch_left = 0;
  logic [7:0]  rx = 8'd0;
  logic [7:0]  addr_seen = 8'd0;
  logic [2:0]  master_ack = 3'd0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        cur_scl;
  logic        cur_sda;
  int          start_count = 0;
  int          stop_count = 0;

  // Monitor state.
  int          busy_run = 0;
  int          last_busy_len = 0;
  int          valid_count = 0;
  int          nack_count = 0;
  logic        busy_prev = 1'b0;

  assign scl_pad = !(o_scl_oe || slave_scl_low);
  assign sda_pad = !(o_sda_oe || slave_sda_low);

  i2c_adc24_reader #(.DIV_QTR(4), .DEV_ADDR(7'h40)) dut (
    .pll_clk_cpu_int(pll_clk_cpu_int),
    .RST_EXT_N(RST_EXT_N),
    .i_enable(i_enable),
    .DRDY_ADC(DRDY_ADC),
    .i_scl(scl_pad),
    .i_sda(sda_pad),
    .o_scl_oe(o_scl_oe),
    .o_sda_oe(o_sda_oe),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_nack_err(o_nack_err),
    .o_overrun_cnt(o_overrun_cnt)
  );

  always #5 pll_clk_cpu_int = ~pll_clk_cpu_int;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // ADC slave model. It tracks START/STOP and SCL edges on the pads, answers
  // its address, and shifts out adc_word. It can stretch SCL once.
  always @(negedge pll_clk_cpu_int) begin
    if (!RST_EXT_N) begin
      slave_active  = 1'b0;
      slave_sda_low = 1'b0;
      slave_scl_low = 1'b0;
      stretch_left  = 0;
      prev_scl      = 1'b1;
      prev_sda      = 1'b1;
    end else begin
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) slave_scl_low = 1'b0;
      end else if (stretch_req && slave_active && byte_no == 2 && nbit == 3 && !prev_scl && !o_scl_oe) begin
        slave_scl_low = 1'b1;
        stretch_left  = 10;
        stretch_req   = 1'b0;
      end
      cur_scl = !(o_scl_oe || slave_scl_low);
      cur_sda = !(o_sda_oe || slave_sda_low);
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        slave_active = 1'b1;
        byte_no      = 0;
        nbit         = 0;
        rx           = 8'd0;
        master_ack   = 3'd0;
        start_count++;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        slave_active  = 1'b0;
        slave_sda_low = 1'b0;
        stop_count++;
      end else if (slave_active && !prev_scl && cur_scl) begin
        if (nbit < 8) rx = {rx[6:0], cur_sda};
        else if (byte_no > 0) master_ack[byte_no-1] = !cur_sda;
        nbit++;
      end else if (slave_active && prev_scl && !cur_scl) begin
        if (nbit == 8) begin
          if (byte_no == 0) begin
            addr_seen     = rx;
            slave_sda_low = !nack_mode;
          end else begin
            slave_sda_low = 1'b0;
          end
        end else if (nbit == 9) begin
          nbit = 0;
          if (byte_no == 0 && nack_mode) begin
            slave_active  = 1'b0;
            slave_sda_low = 1'b0;
          end else begin
            byte_no++;
            if (byte_no > 3) begin
              slave_active  = 1'b0;
              slave_sda_low = 1'b0;
            end else begin
              slave_sda_low = !adc_word[23 - 8*(byte_no-1)];
            end
          end
        end else if (nbit >= 1 && byte_no > 0) begin
          slave_sda_low = !adc_word[23 - 8*(byte_no-1) - nbit];
        end
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  // Output monitor: busy length, NACK pulses, and the scoreboard comparison
  // made whenever a sample is delivered.
  always @(negedge pll_clk_cpu_int) begin
    if (o_busy) begin
      busy_run++;
    end else if (busy_prev) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
    if (o_valid) begin
      valid_count++;
      checkOutput("valid_at_busy_fall", {30'd0, busy_prev, o_busy}, 32'd2);
      if (exp_q.size() > 0) checkOutput("sample_data", o_data, exp_q.pop_front());
      else checkOutput("unexpected_valid", o_valid, 0);
    end
    if (o_nack_err) nack_count++;
    busy_prev = o_busy;
  end

  // Pull DRDY low and check the start latency. The expected sample is queued
  // when the transfer is expected to complete.
  task automatic applyStimulus(input logic [23:0] word, input logic expect_sample, input logic expect_start);
    adc_word = word;
    if (expect_sample) exp_q.push_back(word);
    @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b0;
    repeat (2) @(negedge pll_clk_cpu_int);
    checkOutput("busy_before_latency", o_busy, 0);
    @(negedge pll_clk_cpu_int);
    checkOutput("start_latency", {o_busy, o_sda_oe, o_scl_oe}, expect_start ? 3'b110 : 3'b000);
    repeat (3) @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b1;
  endtask

  task automatic pulse_drdy();
    @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b0;
    repeat (4) @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 4000) begin
      @(negedge pll_clk_cpu_int);
      n++;
    end
    checkOutput("transfer_ends", o_busy, 0);
    repeat (2) @(negedge pll_clk_cpu_int);
  endtask

  // Place a second DRDY fall at a chosen offset from the first. With
  // offset 608 it lands in the last busy cycle; with 609 it lands in the
  // first idle cycle.
  task automatic boundary_case(input int offset, input logic [23:0] word2, input logic expect_new);
    int ov_before = int'(o_overrun_cnt);
    adc_word = 24'h0F0F0F;
    exp_q.push_back(24'h0F0F0F);
    @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b0;
    repeat (5) @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b1;
    repeat (offset - 5) @(negedge pll_clk_cpu_int);
    DRDY_ADC = 1'b0;
    adc_word = word2;
    if (expect_new) exp_q.push_back(word2);
    repeat (612 - offset) @(negedge pll_clk_cpu_int);
    checkOutput("boundary_busy", o_busy, expect_new);
    DRDY_ADC = 1'b1;
    wait_idle();
    checkOutput("boundary_overrun", o_overrun_cnt, ov_before + (expect_new ? 0 : 1));
  endtask

  initial begin
    int v0;
    int s0;
    int n;

    // Reset values.
    repeat (3) @(negedge pll_clk_cpu_int);
    checkOutput("reset_ctrl", {o_scl_oe, o_sda_oe, o_valid, o_busy, o_nack_err}, 0);
    checkOutput("reset_data", o_data, 0);
    checkOutput("reset_overrun", o_overrun_cnt, 0);
    RST_EXT_N = 1'b1;
    repeat (5) @(negedge pll_clk_cpu_int);

    // Normal read.
    $display("[TB] normal read");
    v0 = valid_count;
    s0 = stop_count;
    applyStimulus(24'h800001, 1'b1, 1'b1);
    wait_idle();
    checkOutput("addr_byte", addr_seen, 8'h81);
    checkOutput("master_acks", master_ack, 3'b011);
    checkOutput("busy_len", last_busy_len, 608);
    checkOutput("valid_pulses", valid_count - v0, 1);
    checkOutput("stop_seen", stop_count - s0, 1);

    // Address NACK.
    $display("[TB] address nack");
    nack_mode = 1'b1;
    v0 = valid_count;
    s0 = stop_count;
    applyStimulus(24'h123123, 1'b0, 1'b1);
    wait_idle();
    nack_mode = 1'b0;
    checkOutput("nack_pulses", nack_count, 1);
    checkOutput("nack_busy_len", last_busy_len, 176);
    checkOutput("nack_stop_seen", stop_count - s0, 1);
    checkOutput("nack_no_valid", valid_count - v0, 0);
    checkOutput("nack_data_kept", o_data, 24'h800001);

    // Clock stretching.
    $display("[TB] clock stretch");
    stretch_req = 1'b1;
    applyStimulus(24'h5A3C7E, 1'b1, 1'b1);
    wait_idle();
    checkOutput("stretch_used", stretch_req, 0);
    checkOutput("stretch_busy_len", last_busy_len, 618);

    // Overrun.
    $display("[TB] overrun");
    v0 = valid_count;
    applyStimulus(24'h123456, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (40) @(negedge pll_clk_cpu_int);
      pulse_drdy();
    end
    wait_idle();
    checkOutput("overrun_cnt", o_overrun_cnt, 3);
    checkOutput("overrun_valids", valid_count - v0, 1);

    // Asynchronous reset in the middle of byte 1.
    $display("[TB] reset mid-transfer");
    applyStimulus(24'hABCDEF, 1'b0, 1'b1);
    n = 0;
    while (!(byte_no == 1 && nbit == 3 && o_scl_oe) && n < 3000) begin
      @(negedge pll_clk_cpu_int);
      n++;
    end
    checkOutput("reach_byte1", o_scl_oe, 1);
    #3;
    RST_EXT_N = 1'b0;
    #1;
    checkOutput("reset_async_lines", {o_scl_oe, o_sda_oe, o_busy}, 0);
    checkOutput("reset_async_overrun", o_overrun_cnt, 0);
    repeat (3) @(negedge pll_clk_cpu_int);
    RST_EXT_N = 1'b1;
    repeat (5) @(negedge pll_clk_cpu_int);
    applyStimulus(24'hFEDCBA, 1'b1, 1'b1);
    wait_idle();
    checkOutput("after_reset_busy_len", last_busy_len, 608);

    // Enable gating.
    $display("[TB] enable gating");
    i_enable = 1'b0;
    s0 = start_count;
    applyStimulus(24'h111111, 1'b0, 1'b0);
    repeat (30) @(negedge pll_clk_cpu_int);
    checkOutput("disabled_no_start", start_count, s0);
    checkOutput("disabled_no_overrun", o_overrun_cnt, 0);
    i_enable = 1'b1;
    v0 = valid_count;
    applyStimulus(24'h00FF00, 1'b1, 1'b1);
    repeat (100) @(negedge pll_clk_cpu_int);
    i_enable = 1'b0;
    wait_idle();
    checkOutput("drop_enable_valid", valid_count - v0, 1);
    checkOutput("drop_enable_busy_len", last_busy_len, 608);
    i_enable = 1'b1;

    // DRDY fall at the busy-to-idle boundary.
    $display("[TB] busy boundary");
    boundary_case(608, 24'h777777, 1'b0);
    boundary_case(609, 24'h3C5AA5, 1'b1);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
